// File: rtl/sha1_pkg.sv
// Shared constants, state encoding and the last-word masking helper for the SHA-1 padder.
package sha1_pkg;

  localparam int unsigned SHA1_BLOCK_W  = 512;
  localparam int unsigned SHA1_WORDS    = 16;
  localparam int unsigned SHA1_LEN_BYTE = 56;
  localparam logic [7:0]  SHA1_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {S_FILL, S_FULL, S_SPILL, S_FINAL} sha1_pad_state_e;

  // Keeps the top n bytes, writes the 0x80 marker at byte n, zeroes the rest (n < 4).
  function automatic logic [31:0] sha1_mask_last(input logic [31:0] word, input logic [2:0] n);
    logic [31:0] res;
    res = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(n)) begin
        res[31-8*b -: 8] = word[31-8*b -: 8];
      end else if (b == int'(n)) begin
        res[31-8*b -: 8] = SHA1_PAD_BYTE;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sha1_padder.sv
// Packs a big-endian 32-bit word stream into 512-bit SHA-1 blocks and applies
// the 0x80 / zero-fill / 64-bit bit-length padding.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             in_data_i,
  input  logic                    in_last_i,
  input  logic [2:0]              in_bytes_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [SHA1_BLOCK_W-1:0] out_block_o,
  output logic                    out_first_o,
  output logic                    out_last_o
);

  localparam int unsigned CNT_W = LEN_W - 3;

  sha1_pad_state_e  r_state, w_state_d;
  logic [31:0]      r_buf   [SHA1_WORDS];
  logic [31:0]      w_buf_d [SHA1_WORDS];
  logic [3:0]       r_wptr, w_wptr_d, w_wptr_inc;
  logic [CNT_W-1:0] r_nbytes, w_nbytes_d, w_total;
  logic             r_first, w_first_d;
  logic             r_mark_pend, w_mark_pend_d;
  logic [63:0]      r_len, w_len_d, w_len;
  logic             r_in_ready, r_out_valid, r_out_last;
  logic             w_in_fire, w_out_fire;
  logic [2:0]       w_n;
  logic [6:0]       w_p;

  assign w_in_fire  = in_valid_i & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready_i;
  assign w_n        = (in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
  assign w_p        = {1'b0, r_wptr, 2'b00} + {4'b0000, w_n};
  assign w_wptr_inc = r_wptr + 4'd1;
  assign w_total    = r_nbytes + CNT_W'(w_n);

  // Bit length, zero-extended into the 64-bit length field.
  always_comb begin
    w_len = '0;
    w_len[LEN_W-1:0] = {w_total, 3'b000};
  end

  always_comb begin
    w_state_d     = r_state;
    w_buf_d       = r_buf;
    w_wptr_d      = r_wptr;
    w_nbytes_d    = r_nbytes;
    w_first_d     = r_first;
    w_mark_pend_d = r_mark_pend;
    w_len_d       = r_len;
    unique case (r_state)
      S_FILL: begin
        if (w_in_fire && !in_last_i) begin
          w_buf_d[r_wptr] = in_data_i;
          w_nbytes_d      = r_nbytes + CNT_W'(4);
          if (r_wptr == 4'd15) w_state_d = S_FULL;
          else                 w_wptr_d  = w_wptr_inc;
        end else if (w_in_fire) begin
          w_nbytes_d = w_total;
          w_len_d    = w_len;
          // A full last word pushes the marker into the next word, or the next block.
          if (w_n == 3'd4) begin
            w_buf_d[r_wptr] = in_data_i;
            if (r_wptr != 4'd15) w_buf_d[w_wptr_inc] = {SHA1_PAD_BYTE, 24'h0};
            else                 w_mark_pend_d       = 1'b1;
          end else begin
            w_buf_d[r_wptr] = sha1_mask_last(in_data_i, w_n);
          end
          if (w_p < 7'(SHA1_LEN_BYTE)) begin
            w_buf_d[14] = w_len[63:32];
            w_buf_d[15] = w_len[31:0];
            w_state_d   = S_FINAL;
          end else begin
            w_state_d = S_SPILL;
          end
        end
      end
      S_FULL: begin
        if (w_out_fire) begin
          for (int i = 0; i < SHA1_WORDS; i++) w_buf_d[i] = '0;
          w_first_d = 1'b0;
          w_wptr_d  = '0;
          w_state_d = S_FILL;
        end
      end
      S_SPILL: begin
        if (w_out_fire) begin
          for (int i = 0; i < SHA1_WORDS; i++) w_buf_d[i] = '0;
          if (r_mark_pend) w_buf_d[0] = {SHA1_PAD_BYTE, 24'h0};
          w_buf_d[14] = r_len[63:32];
          w_buf_d[15] = r_len[31:0];
          w_first_d   = 1'b0;
          w_state_d   = S_FINAL;
        end
      end
      S_FINAL: begin
        if (w_out_fire) begin
          for (int i = 0; i < SHA1_WORDS; i++) w_buf_d[i] = '0;
          w_wptr_d      = '0;
          w_nbytes_d    = '0;
          w_first_d     = 1'b1;
          w_mark_pend_d = 1'b0;
          w_state_d     = S_FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_FILL;
      for (int i = 0; i < SHA1_WORDS; i++) r_buf[i] <= '0;
      r_wptr      <= '0;
      r_nbytes    <= '0;
      r_first     <= 1'b1;
      r_mark_pend <= 1'b0;
      r_len       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_buf       <= w_buf_d;
      r_wptr      <= w_wptr_d;
      r_nbytes    <= w_nbytes_d;
      r_first     <= w_first_d;
      r_mark_pend <= w_mark_pend_d;
      r_len       <= w_len_d;
      r_in_ready  <= (w_state_d == S_FILL);
      r_out_valid <= (w_state_d != S_FILL);
      r_out_last  <= (w_state_d == S_FINAL);
    end
  end

  for (genvar g = 0; g < SHA1_WORDS; g++) begin : g_out
    assign out_block_o[SHA1_BLOCK_W-1-32*g -: 32] = r_buf[g];
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_first_o = r_first;
  assign out_last_o  = r_out_last;

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: random messages checked against a byte-level padding model.
module tb_sha1_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         out_valid, out_ready, out_first, out_last;
  logic [511:0] out_block;

  always #5 clk = ~clk;

  sha1_padder #(.LEN_W(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_bytes_i  (in_bytes),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_block_o (out_block),
    .out_first_o (out_first),
    .out_last_o  (out_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [511:0] exp_blk[$], got_blk[$];
  bit           exp_first[$], exp_last[$], got_first[$], got_last[$];

  bit   rand_rdy  = 1'b0;
  logic rdy_force = 1'b1;

  // Sole driver of out_ready; applied 2 time units after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_blk.push_back(out_block);
      got_first.push_back(out_first);
      got_last.push_back(out_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference padding: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic model_msg(input byte unsigned msg[$]);
    byte unsigned p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nb;
    p    = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      exp_last.push_back(b == nb - 1);
    end
  endtask

  task automatic clear_queues();
    exp_blk.delete(); exp_first.delete(); exp_last.delete();
    got_blk.delete(); got_first.delete(); got_last.delete();
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb,
                           input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL in_accept_timeout: in_ready=%0b required 1 within 300 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'b0;
    in_bytes = 3'($urandom);
  endtask

  task automatic send_msg(input byte unsigned msg[$], input bit tail_empty, input bit gaps);
    int          len, nfull, lastn;
    logic [31:0] d;
    logic [2:0]  nb;
    len   = msg.size();
    nfull = len / 4;
    lastn = len % 4;
    if (lastn == 0 && len > 0 && !tail_empty) begin
      nfull = nfull - 1;
      lastn = 4;
    end
    for (int w = 0; w < nfull; w++)
      send_word({msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]}, 1'b0, 3'd0, gaps);
    d = $urandom;
    for (int b = 0; b < lastn; b++) d[31-8*b -: 8] = msg[4*nfull+b];
    nb = 3'(lastn);
    if (lastn == 4) nb = 3'($urandom_range(4, 7));
    send_word(d, 1'b1, nb, gaps);
  endtask

  task automatic make_msg(input int len, output byte unsigned m[$]);
    m.delete();
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %0b required 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL release_in_ready_early: got %0b required 0", in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL release_in_ready: got %0b required 1", in_ready);
    end
    n_cmp++;
    if (out_first !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: first=%0b valid=%0b required first=1 valid=0",
               out_first, out_valid);
    end
  endtask

  task automatic test_known_vectors();
    int           lens[5] = '{3, 0, 55, 56, 64};
    byte unsigned m[$];
    int           t;
    for (int k = 0; k < 5; k++) begin
      clear_queues();
      make_msg(lens[k], m);
      if (k == 0) m = '{8'h61, 8'h62, 8'h63};
      model_msg(m);
      send_msg(m, 1'b0, 1'b0);
      t = 0;
      while (got_blk.size() < exp_blk.size() && t < 100) begin @(posedge clk); #1; t++; end
      n_cmp++;
      if (got_blk.size() != exp_blk.size()) begin
        n_err++;
        $display("FAIL known_len%0d_count: got %0d blocks required %0d",
                 lens[k], got_blk.size(), exp_blk.size());
      end
      for (int i = 0; i < got_blk.size() && i < exp_blk.size(); i++) begin
        n_cmp++;
        if (got_blk[i] !== exp_blk[i] || got_first[i] !== exp_first[i] ||
            got_last[i] !== exp_last[i]) begin
          n_err++;
          $display("FAIL known_len%0d_blk%0d: got %h f%0b l%0b required %h f%0b l%0b",
                   lens[k], i, got_blk[i], got_first[i], got_last[i],
                   exp_blk[i], exp_first[i], exp_last[i]);
        end
      end
      if (got_blk.size() > 0) begin
        n_cmp++;
        if (got_blk[got_blk.size()-1][31:0] !== 32'(8 * lens[k])) begin
          n_err++;
          $display("FAIL known_len%0d_bitlen: got %h required %h", lens[k],
                   got_blk[got_blk.size()-1][31:0], 32'(8 * lens[k]));
        end
        if (k == 0) begin
          n_cmp++;
          if (got_blk[0][511:480] !== 32'h61626380) begin
            n_err++;
            $display("FAIL abc_word0: got %h required 61626380", got_blk[0][511:480]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    byte unsigned m[$];
    int           t;
    rand_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      clear_queues();
      make_msg($urandom_range(0, 140), m);
      model_msg(m);
      send_msg(m, 1'($urandom_range(0, 1)), 1'b1);
      t = 0;
      while (got_blk.size() < exp_blk.size() && t < 400) begin @(posedge clk); #1; t++; end
      n_cmp++;
      if (got_blk.size() != exp_blk.size()) begin
        n_err++;
        $display("FAIL random%0d_count (len %0d): got %0d blocks required %0d",
                 k, m.size(), got_blk.size(), exp_blk.size());
      end
      for (int i = 0; i < got_blk.size() && i < exp_blk.size(); i++) begin
        n_cmp++;
        if (got_blk[i] !== exp_blk[i] || got_first[i] !== exp_first[i] ||
            got_last[i] !== exp_last[i]) begin
          n_err++;
          $display("FAIL random%0d_blk%0d (len %0d): got %h f%0b l%0b required %h f%0b l%0b",
                   k, i, m.size(), got_blk[i], got_first[i], got_last[i],
                   exp_blk[i], exp_first[i], exp_last[i]);
        end
      end
    end
    rand_rdy = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_backpressure();
    byte unsigned m[$];
    logic [511:0] snap;
    int           t;
    clear_queues();
    rdy_force = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    model_msg(m);
    send_msg(m, 1'b0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    snap = out_block;
    n_cmp++;
    if (snap !== exp_blk[0]) begin
      n_err++; $display("FAIL bp_block: got %h required %h", snap, exp_blk[0]);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom); in_bytes = 3'($urandom);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_block !== exp_blk[0] ||
          out_first !== 1'b1 || out_last !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold_c%0d: valid=%0b ready=%0b f=%0b l=%0b blk=%h required 1 0 1 1 %h",
                 c, out_valid, in_ready, out_first, out_last, out_block, exp_blk[0]);
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    rdy_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || got_blk.size() != 1) begin
      n_err++;
      $display("FAIL bp_release: valid=%0b captured=%0d required valid=0 captured=1",
               out_valid, got_blk.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    byte unsigned m[$];
    int           t;
    for (int w = 0; w < 5; w++) send_word($urandom, 1'b0, 3'd0, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: valid=%0b ready=%0b required 0 0", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_queues();
    m = '{8'h61, 8'h62, 8'h63};
    model_msg(m);
    send_msg(m, 1'b0, 1'b0);
    t = 0;
    while (got_blk.size() < 1 && t < 50) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (got_blk.size() != 1) begin
      n_err++; $display("FAIL midreset_count: got %0d blocks required 1", got_blk.size());
    end else begin
      n_cmp++;
      if (got_blk[0] !== exp_blk[0] || got_first[0] !== 1'b1 || got_last[0] !== 1'b1) begin
        n_err++;
        $display("FAIL midreset_abc: got %h f%0b l%0b required %h f1 l1",
                 got_blk[0], got_first[0], got_last[0], exp_blk[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
